seq_magnitude_comparator: RTL and testbench

SEQ_MAGNITUDE_COMPARATOR -- requirements
Module: seq_magnitude_comparator

---
 rtl/cmp_pkg.sv | 34 +++
 rtl/cmp_chunk.sv | 34 +++
 rtl/seq_magnitude_comparator.sv | 143 ++++++++++++++
 tb/tb_seq_magnitude_comparator.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// +----------------------------------------------------------------------+
// | cmp_pkg : shared FSM state and result encodings for the comparator    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package cmp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } cmp_state_e;

    // Result flags are packed as {eq, gt, lt}.
    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_EQ   = 3'b100;
    localparam logic [2:0] RES_GT   = 3'b010;
    localparam logic [2:0] RES_LT   = 3'b001;

    function automatic logic [2:0] res_from_slice(input logic s_gt, input logic s_lt);
        logic [2:0] res;
        res = RES_EQ;
        if (s_gt) begin
            res = RES_GT;
        end else if (s_lt) begin
            res = RES_LT;
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cmp_chunk.sv
// +----------------------------------------------------------------------+
// | cmp_chunk : combinational magnitude compare of one CHUNK-bit slice,   |
// |             with optional sign-flip of the slice MSB                  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module cmp_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_s,
    input  logic [CHUNK-1:0] b_s,
    input  logic             flip_msb,
    output logic             s_gt,
    output logic             s_lt
);

    localparam logic [CHUNK-1:0] C_MSB_BIT = CHUNK'(1) << (CHUNK - 1);

    logic [CHUNK-1:0] w_mask;
    logic [CHUNK-1:0] w_a;
    logic [CHUNK-1:0] w_b;

    // Inverting both sign bits maps two's-complement order onto unsigned order.
    assign w_mask = flip_msb ? C_MSB_BIT : '0;
    assign w_a    = a_s ^ w_mask;
    assign w_b    = b_s ^ w_mask;

    assign s_gt = (w_a > w_b);
    assign s_lt = (w_a < w_b);

endmodule

`default_nettype wire

// File: rtl/seq_magnitude_comparator.sv
// +----------------------------------------------------------------------+
// | seq_magnitude_comparator : multi-cycle signed/unsigned comparator,    |
// |                            MSB chunk first with early exit            |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module seq_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [IDXW-1:0] IDX_MSB = IDXW'(NCHUNK - 1);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] RUN  = ST_RUN;
    localparam logic [1:0] DONE = ST_DONE;

    logic [1:0]       state_q, state_d;
    logic [IDXW-1:0]  idx_q,   idx_d;
    logic [WIDTH-1:0] a_q,     a_d;
    logic [WIDTH-1:0] b_q,     b_d;
    logic             sm_q,    sm_d;
    logic [2:0]       res_q,   res_d;

    logic [CHUNK-1:0] w_a_s;
    logic [CHUNK-1:0] w_b_s;
    logic             w_flip;
    logic             w_s_gt;
    logic             w_s_lt;
    logic             w_accept;

    always_comb begin
        w_a_s = '0;
        w_b_s = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_q == IDXW'(i)) begin
                w_a_s = a_q[i*CHUNK +: CHUNK];
                w_b_s = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    assign w_flip = sm_q && (idx_q == IDX_MSB);

    cmp_chunk #(
        .CHUNK    (CHUNK)
    ) u_cmp_chunk (
        .a_s      (w_a_s),
        .b_s      (w_b_s),
        .flip_msb (w_flip),
        .s_gt     (w_s_gt),
        .s_lt     (w_s_lt)
    );

    assign w_accept = start && ((state_q == IDLE) || (state_q == DONE));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sm_d    = sm_q;
        res_d   = res_q;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            RUN: begin
                if (w_s_gt || w_s_lt) begin
                    res_d   = res_from_slice(w_s_gt, w_s_lt);
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    res_d   = RES_EQ;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Acceptance overrides the per-state defaults so DONE can chain straight into RUN.
        if (w_accept) begin
            a_d     = a;
            b_d     = b;
            sm_d    = signed_mode;
            idx_d   = IDX_MSB;
            res_d   = RES_NONE;
            state_d = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sm_q    <= 1'b0;
            res_q   <= RES_NONE;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sm_q    <= sm_d;
            res_q   <= res_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign eq   = res_q[2];
    assign gt   = res_q[1];
    assign lt   = res_q[0];

endmodule

`default_nettype wire

// File: tb/tb_seq_magnitude_comparator.sv
// +----------------------------------------------------------------------+
// | tb_seq_magnitude_comparator : directed self-checking bench            |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_seq_magnitude_comparator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_mode;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic        eq;
    logic        gt;
    logic        lt;

    int tests = 0;
    int fails = 0;

    seq_magnitude_comparator #(
        .WIDTH       (16),
        .CHUNK       (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .eq          (eq),
        .gt          (gt),
        .lt          (lt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advances until done is seen; k = edges waited, nb = busy samples along the way.
    task automatic wait_done(input string tag, output int k, output int nb);
        k  = 0;
        nb = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (busy) nb++;
            if (done) begin
                k = c;
                break;
            end
        end
        if (k == 0) chk({tag, " timeout"}, {31'd0, done}, 32'd1);
    endtask

    task automatic run_cmp(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                           input logic isg, input logic [2:0] exp, input int expk);
        int k;
        int nb;
        a = ia; b = ib; signed_mode = isg; start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, " busy_at_accept"}, {31'd0, busy}, 32'd1);
        wait_done(tag, k, nb);
        nb++;
        chk({tag, " latency"}, k, expk);
        chk({tag, " flags"}, {29'd0, eq, gt, lt}, {29'd0, exp});
        chk({tag, " busy_cycles"}, nb, expk);
        tick();
        chk({tag, " hold_in_idle"}, {27'd0, busy, done, eq, gt, lt}, {27'd0, 2'b00, exp});
    endtask

    initial begin
        int k;
        int nb;
        int seen_done;

        rst = 1'b1; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
        tick();
        tick();
        chk("reset_outputs", {27'd0, busy, done, eq, gt, lt}, 32'd0);
        rst = 1'b0;
        tick();

        run_cmp("u_eq_1234",      16'h1234, 16'h1234, 1'b0, 3'b100, 4);
        run_cmp("u_gt_8000_7fff", 16'h8000, 16'h7FFF, 1'b0, 3'b010, 1);
        run_cmp("s_lt_8000_7fff", 16'h8000, 16'h7FFF, 1'b1, 3'b001, 1);
        run_cmp("u_lt_1234_1235", 16'h1234, 16'h1235, 1'b0, 3'b001, 4);
        run_cmp("s_gt_ffff_fffe", 16'hFFFF, 16'hFFFE, 1'b1, 3'b010, 4);
        run_cmp("s_gt_0001_ffff", 16'h0001, 16'hFFFF, 1'b1, 3'b010, 1);

        // Start re-pulsed with new operands in the second RUN cycle must be ignored.
        a = 16'h1234; b = 16'h1234; signed_mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        a = 16'h0000; b = 16'hFFFF; signed_mode = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("ignore_start", k, nb);
        chk("ignore_start latency", k + 2, 4);
        chk("ignore_start flags", {29'd0, eq, gt, lt}, {29'd0, 3'b100});
        tick();

        // Back-to-back: start stays high, operands switch while the first run is busy.
        a = 16'h00FF; b = 16'h0100; signed_mode = 1'b0; start = 1'b1;
        tick();
        a = 16'h1234; b = 16'h1230;
        wait_done("b2b_first", k, nb);
        chk("b2b_first latency", k, 2);
        chk("b2b_first flags", {29'd0, eq, gt, lt}, {29'd0, 3'b001});
        tick();
        start = 1'b0;
        chk("b2b_second run_no_bubble", {27'd0, busy, done, eq, gt, lt}, {27'd0, 5'b10000});
        wait_done("b2b_second", k, nb);
        chk("b2b_second latency", k, 4);
        chk("b2b_second flags", {29'd0, eq, gt, lt}, {29'd0, 3'b010});
        tick();
        chk("b2b_idle", {27'd0, busy, done}, 32'd0);

        // Reset in the second RUN cycle aborts without a done pulse.
        a = 16'h1234; b = 16'h1234; signed_mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("abort_outputs", {27'd0, busy, done, eq, gt, lt}, 32'd0);
        rst = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done || busy) seen_done++;
        end
        chk("abort_no_done", seen_done, 0);
        run_cmp("after_abort_s_lt", 16'hFFFF, 16'h0001, 1'b1, 3'b001, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
